// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared definitions for the scoreboard hazard unit.
//   fw_sel_e   : forwarding select codes (RF, W, M, E)
//   TNEW_*     : Tnew values of common instruction classes when in E
//   TUSE_BR    : Tuse of a D-stage branch compare
//   BUBBLE_A3  : write address of a bubble (nothing written)
package hazard_ctrl_sb_pkg;

  typedef enum logic [1:0] {
    FW_RF = 2'd0,
    FW_W  = 2'd1,
    FW_M  = 2'd2,
    FW_E  = 2'd3
  } fw_sel_e;

  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TUSE_BR   = 2'd0;

  // A bubble is an all-zero shadow entry; address 0 is never a real destination.
  localparam logic [4:0] BUBBLE_A3 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sb_md_busy_ctr.sv
// Multiply/divide busy counter.
//   clk, reset : clock, synchronous active-high reset
//   start      : 1-cycle pulse, md op starts in E this cycle
//   div        : qualifies start (1 = div, 0 = mult)
//   md_busy    : unit busy (start pulse or counter non-zero)
// A start (re)loads the cycle count; the newest op always wins.
module md_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CW          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic md_busy
);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The start cycle itself counts as busy, so the stall starts with no latency.
  assign md_busy = start | (cnt != '0);

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Scoreboard hazard unit for the 5-stage F/D/E/M/W pipeline.
// Tracks in-flight destinations in a shadow pipeline so only D-stage decode
// info is needed from the datapath.
//   clk, reset             : clock, synchronous active-high reset
//   D_rs, D_rt             : D-stage source addresses
//   D_rs_tuse, D_rt_tuse   : cycles until D consumes each source
//   D_a3, D_tnew           : D-stage destination (0 = none) and its Tnew in E
//   D_md_use               : D instr uses the mult/div unit or HI/LO
//   E_md_start, E_md_div   : md op start pulse in E, and div/mult qualifier
//   stall                  : freeze F/D, bubble into E
//   FW_D_rs/rt             : 0 RF, 1 W, 2 M, 3 E
//   FW_E_rs/rt             : 0 pipe reg, 1 W, 2 M
//   FW_M_rt                : 0 pipe reg, 1 W
//   md_busy                : md unit busy
//   stall_cnt              : stall cycle count (only with HAZARD_PERF_CNT_EN)
// Build option: define HAZARD_PERF_CNT_EN to add the stall_cnt port.
module hazard_ctrl_sb
  import hazard_ctrl_sb_pkg::*;
#(
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] D_rs,
  input  logic [AW-1:0] D_rt,
  input  logic [TW-1:0] D_rs_tuse,
  input  logic [TW-1:0] D_rt_tuse,
  input  logic [AW-1:0] D_a3,
  input  logic [TW-1:0] D_tnew,
  input  logic          D_md_use,
  input  logic          E_md_start,
  input  logic          E_md_div,
  output logic          stall,
  output logic [1:0]    FW_D_rs,
  output logic [1:0]    FW_D_rt,
  output logic [1:0]    FW_E_rs,
  output logic [1:0]    FW_E_rt,
  output logic          FW_M_rt,
  output logic          md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } e_shadow_t;

  typedef struct packed {
    logic [AW-1:0] rt;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } m_shadow_t;

  e_shadow_t     e_q;
  m_shadow_t     m_q;
  logic [AW-1:0] w_a3;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  // Producer in a stage still needs more cycles than the consumer can wait.
  function automatic logic hazard(input logic [AW-1:0] a3, input logic [AW-1:0] addr,
                                  input logic [TW-1:0] tnew, input logic [TW-1:0] tuse);
    return (a3 != AW'(BUBBLE_A3)) && (a3 == addr) && (tnew > tuse);
  endfunction

  // Producer in a stage already holds its result.
  function automatic logic fwd_hit(input logic [AW-1:0] a3, input logic [AW-1:0] addr,
                                   input logic [TW-1:0] tnew);
    return (a3 != AW'(BUBBLE_A3)) && (a3 == addr) && (tnew == '0);
  endfunction

  // Shadow pipeline. W has no Tnew: anything in W has its result.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q  <= '0;
      m_q  <= '0;
      w_a3 <= '0;
    end else begin
      e_q  <= stall ? '0 : '{rs: D_rs, rt: D_rt, a3: D_a3, tnew: D_tnew};
      m_q  <= '{rt: e_q.rt, a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
      w_a3 <= m_q.a3;
    end
  end

  md_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CW          (CW)
  ) u_md_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .start   (E_md_start),
    .div     (E_md_div),
    .md_busy (md_busy)
  );

  assign stall = hazard(e_q.a3, D_rs, e_q.tnew, D_rs_tuse)
               | hazard(e_q.a3, D_rt, e_q.tnew, D_rt_tuse)
               | hazard(m_q.a3, D_rs, m_q.tnew, D_rs_tuse)
               | hazard(m_q.a3, D_rt, m_q.tnew, D_rt_tuse)
               | (D_md_use & md_busy);

  // Youngest producer wins: E before M before W.
  // NOTE: each output gets a default before the priority chain so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    FW_D_rs = FW_RF;
    if      (fwd_hit(e_q.a3, D_rs, e_q.tnew)) FW_D_rs = FW_E;
    else if (fwd_hit(m_q.a3, D_rs, m_q.tnew)) FW_D_rs = FW_M;
    else if (fwd_hit(w_a3,   D_rs, '0))       FW_D_rs = FW_W;

    FW_D_rt = FW_RF;
    if      (fwd_hit(e_q.a3, D_rt, e_q.tnew)) FW_D_rt = FW_E;
    else if (fwd_hit(m_q.a3, D_rt, m_q.tnew)) FW_D_rt = FW_M;
    else if (fwd_hit(w_a3,   D_rt, '0))       FW_D_rt = FW_W;

    FW_E_rs = FW_RF;
    if      (fwd_hit(m_q.a3, e_q.rs, m_q.tnew)) FW_E_rs = FW_M;
    else if (fwd_hit(w_a3,   e_q.rs, '0))       FW_E_rs = FW_W;

    FW_E_rt = FW_RF;
    if      (fwd_hit(m_q.a3, e_q.rt, m_q.tnew)) FW_E_rt = FW_M;
    else if (fwd_hit(w_a3,   e_q.rt, '0))       FW_E_rt = FW_W;

    FW_M_rt = fwd_hit(w_a3, m_q.rt, '0);
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)      stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  // Without the performance option there is no stall counter.
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench for hazard_ctrl_sb: directed scenarios plus randomized
// traffic against an instruction-level reference model.
module tb_hazard_ctrl_sb;
  import hazard_ctrl_sb_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_a3;
  logic [1:0] D_rs_tuse, D_rt_tuse, D_tnew;
  logic       D_md_use, E_md_start, E_md_div;
  logic       stall, FW_M_rt, md_busy;
  logic [1:0] FW_D_rs, FW_D_rt, FW_E_rs, FW_E_rt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  hazard_ctrl_sb #(
    .AW(5), .TW(2), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CW(4)
  ) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_a3(D_a3), .D_tnew(D_tnew), .D_md_use(D_md_use),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .stall(stall), .FW_D_rs(FW_D_rs), .FW_D_rt(FW_D_rt),
    .FW_E_rs(FW_E_rs), .FW_E_rt(FW_E_rt), .FW_M_rt(FW_M_rt),
    .md_busy(md_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] dut_vec;
  assign dut_vec = {stall, FW_D_rs, FW_D_rt, FW_E_rs, FW_E_rt, FW_M_rt, md_busy};

  // ---------------- reference model ----------------
  // Each in-flight instruction keeps its original Tnew-in-E; its remaining
  // Tnew in stage k (0=E, 1=M, 2=W) is Tnew-k floored at 0, and 0 in W.
  typedef struct {
    logic [4:0] rs, rt, a3;
    int         tnew;
  } ins_t;

  ins_t stg[3];
  int   md_left;
  int   exp_cnt;

  function automatic int rem(input int k);
    int r;
    if (k == 2) return 0;
    r = stg[k].tnew - k;
    return (r > 0) ? r : 0;
  endfunction

  function automatic logic m_busy();
    return E_md_start || (md_left > 0);
  endfunction

  function automatic logic m_stall();
    logic s;
    s = D_md_use && m_busy();
    for (int k = 0; k < 2; k++) begin
      if (stg[k].a3 != 0 && stg[k].a3 == D_rs && rem(k) > int'(D_rs_tuse)) s = 1'b1;
      if (stg[k].a3 != 0 && stg[k].a3 == D_rt && rem(k) > int'(D_rt_tuse)) s = 1'b1;
    end
    return s;
  endfunction

  // Youngest stage from 'first' onward holding a ready result; code 3-k.
  function automatic logic [1:0] m_fw(input logic [4:0] addr, input int first);
    if (addr == 0) return 2'd0;
    for (int k = first; k < 3; k++)
      if (stg[k].a3 == addr && rem(k) == 0) return 2'(3 - k);
    return 2'd0;
  endfunction

  function automatic logic [10:0] model_vec();
    logic [1:0] fm;
    fm = m_fw(stg[1].rt, 2);
    return {m_stall(), m_fw(D_rs, 0), m_fw(D_rt, 0),
            m_fw(stg[0].rs, 1), m_fw(stg[0].rt, 1), fm[0], m_busy()};
  endfunction

  task automatic tick();
    logic s;
    s = m_stall();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 3; k++) stg[k] = '{default: 0};
      md_left = 0;
      exp_cnt = 0;
    end else begin
      if (s) exp_cnt++;
      stg[2] = stg[1];
      stg[1] = stg[0];
      if (s) stg[0] = '{default: 0};
      else   stg[0] = '{D_rs, D_rt, D_a3, int'(D_tnew)};
      if (E_md_start)       md_left = E_md_div ? DIV_N : MULT_N;
      else if (md_left > 0) md_left--;
    end
    #2;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rs_tuse, input logic [1:0] rt_tuse,
                       input logic [4:0] a3, input logic [1:0] tnew,
                       input logic md_use, input logic start, input logic div);
    D_rs = rs; D_rt = rt; D_rs_tuse = rs_tuse; D_rt_tuse = rt_tuse;
    D_a3 = a3; D_tnew = tnew; D_md_use = md_use; E_md_start = start; E_md_div = div;
  endtask

  task automatic flush();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (dut_vec !== 11'd0) $display("FAIL reset_outputs: got %h expected 000", dut_vec);
    else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
`endif
  endtask

  task automatic test_load_use();
    flush();
    drive(0, 0, 0, 0, 5'd8, TNEW_LOAD, 0, 0, 0);
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL load_issue_stall: got %b expected 0", stall);
    else passed++;
    tick();
    drive(5'd8, 0, 2'd1, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL load_use_stall: got %b expected 1", stall);
    else passed++;
    tick();
    #1;
    total++;
    if ({stall, FW_D_rs} !== 3'b0_00)
      $display("FAIL load_use_release: got stall=%b fw_d_rs=%0d expected stall=0 fw_d_rs=0",
               stall, FW_D_rs);
    else passed++;
    tick();
    // The load has reached W by the time its consumer is in E.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (FW_E_rs !== 2'd1) $display("FAIL load_use_fw_e_rs: got %0d expected 1", FW_E_rs);
    else passed++;
  endtask

  task automatic test_alu_b2b();
    flush();
    drive(0, 0, 0, 0, 5'd9, TNEW_ALU, 0, 0, 0);
    tick();
    drive(5'd9, 0, TUSE_BR, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL alu_b2b_stall: got %b expected 1", stall);
    else passed++;
    tick();
    #1;
    total++;
    if ({stall, FW_D_rs} !== 3'b0_10)
      $display("FAIL alu_b2b_fwd: got stall=%b fw_d_rs=%0d expected stall=0 fw_d_rs=2",
               stall, FW_D_rs);
    else passed++;
  endtask

  task automatic test_priority();
    flush();
    drive(0, 0, 0, 0, 5'd5, 2'd0, 0, 0, 0);
    repeat (3) tick();
    drive(0, 5'd5, 0, 2'd0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if ({stall, FW_D_rt} !== 3'b0_11)
      $display("FAIL prio_e: got stall=%b fw_d_rt=%0d expected stall=0 fw_d_rt=3", stall, FW_D_rt);
    else passed++;
    tick();
    #1;
    total++;
    if ({FW_D_rt, FW_E_rt} !== 4'b10_10)
      $display("FAIL prio_m: got fw_d_rt=%0d fw_e_rt=%0d expected 2 2", FW_D_rt, FW_E_rt);
    else passed++;
    tick();
    #1;
    total++;
    if ({FW_D_rt, FW_E_rt, FW_M_rt} !== 5'b01_01_1)
      $display("FAIL prio_w: got fw_d_rt=%0d fw_e_rt=%0d fw_m_rt=%0d expected 1 1 1",
               FW_D_rt, FW_E_rt, FW_M_rt);
    else passed++;
  endtask

  task automatic test_zero();
    flush();
    drive(0, 0, 0, 0, 5'd0, TNEW_LOAD, 0, 0, 0);
    tick();
    drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if ({stall, FW_D_rs, FW_D_rt} !== 5'd0)
      $display("FAIL zero_reg: got stall=%b fw_d_rs=%0d fw_d_rt=%0d expected 0 0 0",
               stall, FW_D_rs, FW_D_rt);
    else passed++;
  endtask

  task automatic test_md_div();
    int stalls = 0;
    int fall   = -1;
    flush();
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (stall) stalls++;
      if (!md_busy && fall < 0) fall = i;
      if (stall !== md_busy) begin
        total++;
        $display("FAIL md_stall_tracks_busy: cycle %0d got stall=%b expected %b", i, stall, md_busy);
      end
      tick();
      E_md_start = 1'b0;
      #1;
    end
    total++;
    if (stalls != 11) $display("FAIL md_stall_cycles: got %0d expected 11", stalls);
    else passed++;
    total++;
    if (fall != 11) $display("FAIL md_busy_fall: got cycle %0d expected 11", fall);
    else passed++;
  endtask

  task automatic test_reset_mid();
    flush();
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    E_md_start = 1'b0;
    tick();
    tick();
    // Cycle 3: no md use, so a ready writer of $7 can enter E.
    drive(0, 0, 0, 0, 5'd7, 2'd0, 1'b0, 0, 0);
    #1;
    total++;
    if ({stall, md_busy} !== 2'b01)
      $display("FAIL mid_no_use: got stall=%b md_busy=%b expected 0 1", stall, md_busy);
    else passed++;
    tick();
    // Cycle 4: reset asserted while busy and while E holds $7.
    drive(5'd7, 0, 0, 0, 0, 0, 1'b1, 0, 0);
    reset = 1'b1;
    #1;
    total++;
    if ({stall, FW_D_rs} !== 3'b1_11)
      $display("FAIL mid_pre_reset: got stall=%b fw_d_rs=%0d expected 1 3", stall, FW_D_rs);
    else passed++;
    tick();
    reset = 1'b0;
    drive(5'd7, 5'd7, 0, 0, 0, 0, 1'b1, 0, 0);
    #1;
    total++;
    if (dut_vec !== 11'd0) $display("FAIL mid_post_reset: got %h expected 000", dut_vec);
    else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL mid_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
`endif
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      #1;
      total++;
      if (dut_vec !== model_vec()) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec, model_vec());
      end else passed++;
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (stall_cnt !== 32'(exp_cnt))
        $display("FAIL random_stall_cnt_%0d: got %0d expected %0d", i, stall_cnt, exp_cnt);
      else passed++;
`endif
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) stg[k] = '{default: 0};
    md_left = 0;
    exp_cnt = 0;
    test_reset();
    test_load_use();
    test_alu_b2b();
    test_priority();
    test_zero();
    test_md_div();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
